ahb_master_mux_pipelined: RTL and testbench



---
 rtl/ahb_master_mux_pipelined_if.sv | 49 ++++
 rtl/ahb_master_mux_pipelined.sv | 98 +++++++++
 tb/tb_ahb_master_mux_pipelined.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_master_mux_pipelined_if.sv
// Bus bundle for the AHB master-side mux: packed per-master address/control/write-data
// inputs from the masters and the arbiter, plus the selected shared-bus outputs.
interface ahb_master_mux_pipelined_if #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32
);
    localparam int unsigned MASTER_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    // Arbiter and response-mux side
    logic [MASTER_W-1:0]              HMASTER;
    logic                             HREADY;

    // Per-master request buses, master i in slice i
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] HADDR_M;
    logic [NUM_MASTERS*2-1:0]          HTRANS_M;
    logic [NUM_MASTERS-1:0]            HWRITE_M;
    logic [NUM_MASTERS*3-1:0]          HSIZE_M;
    logic [NUM_MASTERS*3-1:0]          HBURST_M;
    logic [NUM_MASTERS*4-1:0]          HPROT_M;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] HWDATA_M;

    // Shared slave bus
    logic [ADDR_WIDTH-1:0]            HADDR;
    logic [1:0]                       HTRANS;
    logic                             HWRITE;
    logic [2:0]                       HSIZE;
    logic [2:0]                       HBURST;
    logic [3:0]                       HPROT;
    logic [DATA_WIDTH-1:0]            HWDATA;
    logic [MASTER_W-1:0]              HMASTER_D;
    logic                             DPHASE_ACTIVE;

    // The mux drives the shared bus
    modport master (
        input  HMASTER, HREADY,
        input  HADDR_M, HTRANS_M, HWRITE_M, HSIZE_M, HBURST_M, HPROT_M, HWDATA_M,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HMASTER_D, DPHASE_ACTIVE
    );

    // Environment view: masters/arbiter/slaves around the mux
    modport slave (
        output HMASTER, HREADY,
        output HADDR_M, HTRANS_M, HWRITE_M, HSIZE_M, HBURST_M, HPROT_M, HWDATA_M,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HMASTER_D, DPHASE_ACTIVE
    );
endinterface

// File: rtl/ahb_master_mux_pipelined.sv
// AHB master-side mux: combinational address/control select by HMASTER, write data
// selected by a data-phase owner register that only advances on HREADY.
module ahb_master_mux_pipelined #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input logic                        HCLK,
    input logic                        HRESETn,
    ahb_master_mux_pipelined_if.master bus
);
    localparam int unsigned MASTER_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    // One extra bit so the range compare also works when NUM_MASTERS is a power of two
    localparam logic [MASTER_W:0] NUM_M = (MASTER_W+1)'(NUM_MASTERS);

    logic                  addr_inrange;
    logic [ADDR_WIDTH-1:0] haddr_sel;
    logic [1:0]            htrans_sel;
    logic                  hwrite_sel;
    logic [2:0]            hsize_sel;
    logic [2:0]            hburst_sel;
    logic [3:0]            hprot_sel;
    logic [1:0]            htrans_out;

    logic [MASTER_W-1:0]   dmaster_q;
    logic                  dvalid_q;
    logic                  dinrange_q;
    logic [DATA_WIDTH-1:0] hwdata_sel;

    assign addr_inrange = ({1'b0, bus.HMASTER} < NUM_M);

    // Address-phase select
    always_comb begin
        haddr_sel  = '0;
        htrans_sel = '0;
        hwrite_sel = 1'b0;
        hsize_sel  = '0;
        hburst_sel = '0;
        hprot_sel  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (bus.HMASTER == MASTER_W'(i)) begin
                haddr_sel  = bus.HADDR_M[i*ADDR_WIDTH +: ADDR_WIDTH];
                htrans_sel = bus.HTRANS_M[i*2 +: 2];
                hwrite_sel = bus.HWRITE_M[i];
                hsize_sel  = bus.HSIZE_M[i*3 +: 3];
                hburst_sel = bus.HBURST_M[i*3 +: 3];
                hprot_sel  = bus.HPROT_M[i*4 +: 4];
            end
        end
    end

    // Unknown master parks the bus on an IDLE, privileged-data default
    always_comb begin
        if (addr_inrange) begin
            bus.HADDR  = haddr_sel;
            htrans_out = htrans_sel;
            bus.HWRITE = hwrite_sel;
            bus.HSIZE  = hsize_sel;
            bus.HBURST = hburst_sel;
            bus.HPROT  = hprot_sel;
        end else begin
            bus.HADDR  = '0;
            htrans_out = 2'b00;
            bus.HWRITE = 1'b0;
            bus.HSIZE  = 3'b000;
            bus.HBURST = 3'b000;
            bus.HPROT  = 4'b0011;
        end
        bus.HTRANS = htrans_out;
    end

    // Data-phase owner advances only on accepted cycles
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dmaster_q  <= '0;
            dvalid_q   <= 1'b0;
            dinrange_q <= 1'b0;
        end else if (bus.HREADY) begin
            dmaster_q  <= bus.HMASTER;
            dvalid_q   <= htrans_out[1];
            dinrange_q <= addr_inrange;
        end
    end

    always_comb begin
        hwdata_sel = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (dmaster_q == MASTER_W'(i)) begin
                hwdata_sel = bus.HWDATA_M[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.HWDATA        = dinrange_q ? hwdata_sel : '0;
    assign bus.HMASTER_D     = dmaster_q;
    assign bus.DPHASE_ACTIVE = dvalid_q;

endmodule

// File: tb/tb_ahb_master_mux_pipelined.sv
// Directed bench for ahb_master_mux_pipelined: a 4-master and a 5-master instance
// checked against hand-computed values.
module tb_ahb_master_mux_pipelined;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic HCLK;
    logic HRESETn;
    int   checks;
    int   errors;

    logic [31:0] wd4 [4];
    logic [31:0] wd5 [5];

    ahb_master_mux_pipelined_if #(.NUM_MASTERS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus4 ();
    ahb_master_mux_pipelined_if #(.NUM_MASTERS(5), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus5 ();

    ahb_master_mux_pipelined #(.NUM_MASTERS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut4 (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus4)
    );

    ahb_master_mux_pipelined #(.NUM_MASTERS(5), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut5 (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus5)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set4(input int i, input logic [31:0] addr, input logic [1:0] trans,
                        input logic wr, input logic [2:0] size, input logic [2:0] burst,
                        input logic [3:0] prot);
        bus4.HADDR_M[i*AW +: AW] = addr;
        bus4.HTRANS_M[i*2 +: 2]  = trans;
        bus4.HWRITE_M[i]         = wr;
        bus4.HSIZE_M[i*3 +: 3]   = size;
        bus4.HBURST_M[i*3 +: 3]  = burst;
        bus4.HPROT_M[i*4 +: 4]   = prot;
    endtask

    task automatic set5(input int i, input logic [31:0] addr, input logic [1:0] trans,
                        input logic wr, input logic [2:0] size, input logic [2:0] burst,
                        input logic [3:0] prot);
        bus5.HADDR_M[i*AW +: AW] = addr;
        bus5.HTRANS_M[i*2 +: 2]  = trans;
        bus5.HWRITE_M[i]         = wr;
        bus5.HSIZE_M[i*3 +: 3]   = size;
        bus5.HBURST_M[i*3 +: 3]  = burst;
        bus5.HPROT_M[i*4 +: 4]   = prot;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset with random write data
        HRESETn       = 1'b0;
        bus4.HREADY   = 1'b1;
        bus4.HMASTER  = 2'd0;
        bus4.HADDR_M  = '0;
        bus4.HTRANS_M = '0;
        bus4.HWRITE_M = '0;
        bus4.HSIZE_M  = '0;
        bus4.HBURST_M = '0;
        bus4.HPROT_M  = '0;
        bus4.HWDATA_M = {$urandom, $urandom, $urandom, $urandom};
        bus5.HREADY   = 1'b1;
        bus5.HMASTER  = 3'd0;
        bus5.HADDR_M  = '0;
        bus5.HTRANS_M = '0;
        bus5.HWRITE_M = '0;
        bus5.HSIZE_M  = '0;
        bus5.HBURST_M = '0;
        bus5.HPROT_M  = '0;
        bus5.HWDATA_M = {$urandom, $urandom, $urandom, $urandom, $urandom};
        #2;
        check("rst_hwdata", 64'(bus4.HWDATA), 64'h0);
        check("rst_hmaster_d", 64'(bus4.HMASTER_D), 64'h0);
        check("rst_dphase", 64'(bus4.DPHASE_ACTIVE), 64'h0);

        // Reset dominates clock edges
        bus4.HMASTER = 2'd2;
        set4(2, 32'h2000_0000, 2'b10, 1'b1, 3'b010, 3'b000, 4'b0011);
        tick();
        check("rst_hold_hmaster_d", 64'(bus4.HMASTER_D), 64'h0);
        check("rst_hold_dphase", 64'(bus4.DPHASE_ACTIVE), 64'h0);
        check("rst_addr_comb", 64'(bus4.HADDR), 64'h2000_0000);

        // Known write data from here on
        for (int i = 0; i < 4; i++) wd4[i] = 32'hD400_0000 + 32'(i) * 32'h0101_0101;
        for (int i = 0; i < 5; i++) wd5[i] = 32'hE500_0000 + 32'(i) * 32'h0011_0011;
        bus4.HWDATA_M = {wd4[3], wd4[2], wd4[1], wd4[0]};
        bus5.HWDATA_M = {wd5[4], wd5[3], wd5[2], wd5[1], wd5[0]};

        // Release; first accepted edge with master 2 NONSEQ
        HRESETn = 1'b1;
        tick();
        check("rel_hmaster_d", 64'(bus4.HMASTER_D), 64'h2);
        check("rel_dphase", 64'(bus4.DPHASE_ACTIVE), 64'h1);
        check("rel_hwdata", 64'(bus4.HWDATA), 64'(wd4[2]));

        // Steady routing to master 3
        bus4.HMASTER = 2'd3;
        set4(3, 32'h3000_0010, 2'b10, 1'b1, 3'b010, 3'b000, 4'b1010);
        #1;
        check("m3_haddr", 64'(bus4.HADDR), 64'h3000_0010);
        check("m3_htrans", 64'(bus4.HTRANS), 64'h2);
        check("m3_hwrite", 64'(bus4.HWRITE), 64'h1);
        check("m3_hsize", 64'(bus4.HSIZE), 64'h2);
        check("m3_hprot", 64'(bus4.HPROT), 64'ha);
        check("m3_owner_before_edge", 64'(bus4.HMASTER_D), 64'h2);
        tick();
        check("m3_owner", 64'(bus4.HMASTER_D), 64'h3);
        check("m3_hwdata", 64'(bus4.HWDATA), 64'(wd4[3]));

        // Handover 1 -> 0 with three wait states
        bus4.HMASTER = 2'd1;
        set4(1, 32'h1000_0000, 2'b10, 1'b1, 3'b010, 3'b000, 4'b0011);
        set4(0, 32'h0000_0040, 2'b10, 1'b1, 3'b010, 3'b000, 4'b0011);
        tick();
        bus4.HMASTER = 2'd0;
        for (int k = 0; k < 4; k++) begin
            bus4.HREADY = (k == 3);
            #1;
            check("ho_hwdata", 64'(bus4.HWDATA), 64'(wd4[1]));
            check("ho_owner", 64'(bus4.HMASTER_D), 64'h1);
            check("ho_haddr", 64'(bus4.HADDR), 64'h0000_0040);
            check("ho_dphase", 64'(bus4.DPHASE_ACTIVE), 64'h1);
            tick();
        end
        check("ho_new_owner", 64'(bus4.HMASTER_D), 64'h0);
        check("ho_new_hwdata", 64'(bus4.HWDATA), 64'(wd4[0]));

        // BUSY from master 0 ends the active data phase
        set4(0, 32'h0000_0044, 2'b01, 1'b1, 3'b010, 3'b001, 4'b0011);
        tick();
        check("busy_dphase", 64'(bus4.DPHASE_ACTIVE), 64'h0);
        check("busy_owner", 64'(bus4.HMASTER_D), 64'h0);

        // 5-master instance: last legal master, then out-of-range indices
        for (int i = 0; i < 5; i++)
            set5(i, 32'h4444_0000 + 32'(i), 2'b10, 1'b1, 3'b010, 3'b011, 4'b1111);
        bus5.HMASTER = 3'd4;
        tick();
        check("m5_last_owner", 64'(bus5.HMASTER_D), 64'h4);
        check("m5_last_hwdata", 64'(bus5.HWDATA), 64'(wd5[4]));
        check("m5_last_haddr", 64'(bus5.HADDR), 64'h4444_0004);
        bus5.HMASTER = 3'd5;
        #1;
        check("oor5_htrans", 64'(bus5.HTRANS), 64'h0);
        bus5.HMASTER = 3'd7;
        #1;
        check("oor7_htrans", 64'(bus5.HTRANS), 64'h0);
        check("oor7_haddr", 64'(bus5.HADDR), 64'h0);
        check("oor7_hprot", 64'(bus5.HPROT), 64'h3);
        check("oor7_hwrite", 64'(bus5.HWRITE), 64'h0);
        check("oor7_hsize", 64'(bus5.HSIZE), 64'h0);
        check("oor7_hburst", 64'(bus5.HBURST), 64'h0);
        check("oor7_hwdata_prev", 64'(bus5.HWDATA), 64'(wd5[4]));
        tick();
        check("oor7_hwdata", 64'(bus5.HWDATA), 64'h0);
        check("oor7_dphase", 64'(bus5.DPHASE_ACTIVE), 64'h0);
        check("oor7_owner", 64'(bus5.HMASTER_D), 64'h7);

        // INCR4 from master 2, reset asserted between edges
        bus4.HMASTER = 2'd2;
        set4(2, 32'h2000_0100, 2'b10, 1'b1, 3'b010, 3'b011, 4'b0011);
        tick();
        set4(2, 32'h2000_0104, 2'b11, 1'b1, 3'b010, 3'b011, 4'b0011);
        tick();
        check("burst_owner", 64'(bus4.HMASTER_D), 64'h2);
        check("burst_dphase", 64'(bus4.DPHASE_ACTIVE), 64'h1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("arst_hwdata", 64'(bus4.HWDATA), 64'h0);
        check("arst_owner", 64'(bus4.HMASTER_D), 64'h0);
        check("arst_dphase", 64'(bus4.DPHASE_ACTIVE), 64'h0);
        check("arst_haddr", 64'(bus4.HADDR), 64'h2000_0104);
        check("arst_owner5", 64'(bus5.HMASTER_D), 64'h0);
        #2;
        HRESETn = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
